// File: rtl/tower_commander_if.sv
// tower_commander_if: bundles the request, slot-status, command, coin and response signals of
// the tower commander.
//   slave  : commander side (accepts requests, drives slot pulses, coins and responses)
//   master : environment side (player input, tower slots, enemy reward logic)
// Parameters: NUM_SLOTS (slot count), COIN_W (coin counter width).
interface tower_commander_if #(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned COIN_W    = 12
);
   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [SLOT_W-1:0]      req_slot;
   logic [2:0]             req_type;
   logic [NUM_SLOTS-1:0]   slot_used;
   logic [3*NUM_SLOTS-1:0] slot_type;
   logic [NUM_SLOTS-1:0]   enable;
   logic [NUM_SLOTS-1:0]   sell;
   logic [2:0]             type_com;
   logic                   coin_add_valid;
   logic [COIN_W-1:0]      coin_add;
   logic [COIN_W-1:0]      coins;
   logic                   resp_valid;
   logic [1:0]             resp_code;

   modport slave (
      input  req_valid, req_op, req_slot, req_type, slot_used, slot_type, coin_add_valid,
             coin_add,
      output req_ready, enable, sell, type_com, coins, resp_valid, resp_code
   );

   modport master (
      output req_valid, req_op, req_slot, req_type, slot_used, slot_type, coin_add_valid,
             coin_add,
      input  req_ready, enable, sell, type_com, coins, resp_valid, resp_code
   );
endinterface

// File: rtl/tower_commander.sv
// tower_commander: validates place/sell(/upgrade) requests against slot status and the coin
// balance, issues one single-cycle one-hot enable or sell pulse per accepted request, reports a
// status response, and owns the coin counter (kill rewards credited via coin_add).
// Ports:
//   Clk      : system clock
//   Reset_n  : synchronous active-low reset
//   bus      : tower_commander_if.slave (request, slot status, pulses, coins, response)
// Optional feature: define TOWER_UPGRADE_EN to enable op 2 (upgrade); otherwise op 2 is BAD_REQ.
module tower_commander #(
   parameter int unsigned NUM_SLOTS   = 8,
   parameter int unsigned COIN_W      = 12,
   parameter int unsigned START_COINS = 400,
   parameter int unsigned COST_UNIT   = 100,
   parameter int unsigned MAX_TYPE    = 4
) (
   input logic              Clk,
   input logic              Reset_n,
   tower_commander_if.slave bus
);
   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   // Two guard bits: credit + sell refund can exceed 2^(COIN_W+1) before saturation.
   localparam int unsigned WIDE_W = COIN_W + 2;
   typedef logic [WIDE_W-1:0] wide_t;
   localparam wide_t CoinMax = {2'b00, {COIN_W{1'b1}}};

   localparam logic [1:0] OpPlace   = 2'd0;
   localparam logic [1:0] OpSell    = 2'd1;
   localparam logic [1:0] OpUpgrade = 2'd2;

   typedef enum logic [1:0] {
      RespOk           = 2'd0,
      RespNoFunds      = 2'd1,
      RespSlotConflict = 2'd2,
      RespBadReq       = 2'd3
   } resp_e;

   typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [2:0]          type_q, type_d;          // type presented on type_com
   logic [2:0]          old_type_q, old_type_d;  // slot type before an upgrade
   wide_t               cost_q, cost_d;          // deducted in ISSUE
   wide_t               refund_q, refund_d;      // credited in ISSUE (sell)
   resp_e               code_q, code_d;
   logic [COIN_W-1:0]   coins_q, coins_d;

   logic                slot_ok;
   logic                sel_used;
   logic [2:0]          sel_type;
   logic                settled;
   wide_t               place_cost;
   wide_t               coins_w;
   wide_t               coin_sum;

   // Status of the latched slot; an out-of-range slot reads as unused.
   always_comb begin
      slot_ok  = int'(slot_q) < int'(NUM_SLOTS);
      sel_used = 1'b0;
      sel_type = '0;
      if (slot_ok) begin
         sel_used = bus.slot_used[slot_q];
         sel_type = bus.slot_type[int'(slot_q) * 3 +: 3];
      end
   end

   assign place_cost = wide_t'(type_q) * wide_t'(COST_UNIT);
   assign coins_w    = {2'b00, coins_q};

   // Slot status after the command: placed/upgraded slots must read used (and changed type for
   // an upgrade), sold slots must read unused.
   always_comb begin
      case (op_q)
         OpSell:    settled = !sel_used;
         OpUpgrade: settled = sel_used && (sel_type != old_type_q);
         default:   settled = sel_used;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      slot_d     = slot_q;
      type_d     = type_q;
      old_type_d = old_type_q;
      cost_d     = cost_q;
      refund_d   = refund_q;
      code_d     = code_q;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               op_d     = bus.req_op;
               slot_d   = bus.req_slot;
               type_d   = bus.req_type;
               cost_d   = '0;
               refund_d = '0;
               code_d   = RespOk;
               state_d  = StCheck;
            end
         end
         StCheck: begin
            state_d = StIssue;
            case (op_q)
               OpPlace: begin
                  if (type_q == 3'd0 || int'(type_q) > int'(MAX_TYPE) || !slot_ok) begin
                     code_d = RespBadReq;
                  end else if (sel_used) begin
                     code_d = RespSlotConflict;
                  end else if (coins_w < place_cost) begin
                     code_d = RespNoFunds;
                  end else begin
                     cost_d = place_cost;
                  end
               end
               OpSell: begin
                  type_d = '0;
                  if (!sel_used) begin
                     code_d = RespSlotConflict;
                  end else begin
                     refund_d = (wide_t'(sel_type) * wide_t'(COST_UNIT)) >> 1;
                  end
               end
`ifdef TOWER_UPGRADE_EN
               OpUpgrade: begin
                  if (!sel_used) begin
                     code_d = RespSlotConflict;
                  end else if (int'(sel_type) >= int'(MAX_TYPE)) begin
                     code_d = RespBadReq;
                  end else if (coins_w < wide_t'(COST_UNIT)) begin
                     code_d = RespNoFunds;
                  end else begin
                     old_type_d = sel_type;
                     type_d     = sel_type + 3'd1;
                     cost_d     = wide_t'(COST_UNIT);
                  end
               end
`else
               OpUpgrade: code_d = RespBadReq;
`endif
               default: code_d = RespBadReq;
            endcase
            if (code_d != RespOk) state_d = StResp;
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (!settled) code_d = RespSlotConflict;
            state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Coin update: credit in any state, ISSUE adds refund and subtracts cost, then saturate.
   always_comb begin
      coin_sum = coins_w;
      if (bus.coin_add_valid) coin_sum = coin_sum + {2'b00, bus.coin_add};
      if (state_q == StIssue) coin_sum = coin_sum + refund_q - cost_q;
      coins_d = (coin_sum > CoinMax) ? {COIN_W{1'b1}} : coin_sum[COIN_W-1:0];
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q    <= StIdle;
         op_q       <= OpPlace;
         slot_q     <= '0;
         type_q     <= '0;
         old_type_q <= '0;
         cost_q     <= '0;
         refund_q   <= '0;
         code_q     <= RespOk;
         coins_q    <= COIN_W'(START_COINS);
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         slot_q     <= slot_d;
         type_q     <= type_d;
         old_type_q <= old_type_d;
         cost_q     <= cost_d;
         refund_q   <= refund_d;
         code_q     <= code_d;
         coins_q    <= coins_d;
      end
   end

   always_comb begin
      bus.enable   = '0;
      bus.sell     = '0;
      bus.type_com = '0;
      if (state_q == StIssue) begin
         if (op_q == OpSell) begin
            bus.sell[slot_q] = 1'b1;
         end else begin
            bus.enable[slot_q] = 1'b1;
            bus.type_com       = type_q;
         end
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_code  = (state_q == StResp) ? code_q : RespOk;
   assign bus.coins      = coins_q;
endmodule

// File: tb/tb_tower_commander.sv
// Directed testbench for tower_commander with a small tower-slot model that reacts to pulses.
module tb_tower_commander;
   logic Clk;
   logic Reset_n;
   int   n_checks;
   int   n_pass;
   logic [7:0]  used_m;
   logic [23:0] type_m;

   tower_commander_if #(.NUM_SLOTS(8), .COIN_W(12)) bus ();

   tower_commander dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   assign bus.slot_used = used_m;
   assign bus.slot_type = type_m;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic credit(input int amt);
      bus.coin_add_valid = 1'b1;
      bus.coin_add       = 12'(amt);
      @(negedge Clk);
      bus.coin_add_valid = 1'b0;
      bus.coin_add       = '0;
   endtask

   // Issues one request at a negedge and follows it to the response. A credit of add_amt is
   // driven in the cycle add_cyc after acceptance (0 = none).
   task automatic run_req(input string tag, input int op, input int slot, input int typ,
                          input int add_cyc, input int add_amt, input int exp_code,
                          input int exp_lat, input int exp_en, input int exp_sell,
                          input int exp_tc, input int exp_coins);
      int lat;
      int code;
      int tc;
      logic [7:0] en_acc;
      logic [7:0] sell_acc;
      lat      = -1;
      code     = -1;
      tc       = 0;
      en_acc   = '0;
      sell_acc = '0;
      check_eq({tag, ".ready"}, int'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'(op);
      bus.req_slot  = 3'(slot);
      bus.req_type  = 3'(typ);
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         @(negedge Clk);
         en_acc   = en_acc | bus.enable;
         sell_acc = sell_acc | bus.sell;
         if (bus.enable != '0) tc = int'(bus.type_com);
         for (int i = 0; i < 8; i++) begin
            if (bus.enable[i]) begin
               used_m[i]          = 1'b1;
               type_m[3*i +: 3] = bus.type_com;
            end
            if (bus.sell[i]) begin
               used_m[i]          = 1'b0;
               type_m[3*i +: 3] = 3'd0;
            end
         end
         bus.coin_add_valid = (k == add_cyc);
         bus.coin_add       = (k == add_cyc) ? 12'(add_amt) : 12'd0;
         if (bus.resp_valid) begin
            lat  = k;
            code = int'(bus.resp_code);
         end
      end
      bus.coin_add_valid = 1'b0;
      bus.coin_add       = '0;
      check_eq({tag, ".lat"}, lat, exp_lat);
      check_eq({tag, ".code"}, code, exp_code);
      check_eq({tag, ".enable"}, int'(en_acc), exp_en);
      check_eq({tag, ".sell"}, int'(sell_acc), exp_sell);
      check_eq({tag, ".type_com"}, tc, exp_tc);
      check_eq({tag, ".coins"}, int'(bus.coins), exp_coins);
      @(negedge Clk);
   endtask

   initial begin
      int seen_resp;
      n_checks           = 0;
      n_pass             = 0;
      used_m             = '0;
      type_m             = '0;
      bus.req_valid      = 1'b0;
      bus.req_op         = '0;
      bus.req_slot       = '0;
      bus.req_type       = '0;
      bus.coin_add_valid = 1'b0;
      bus.coin_add       = '0;
      Reset_n            = 1'b0;
      @(negedge Clk);
      do_reset();

      check_eq("rst.coins", int'(bus.coins), 400);
      check_eq("rst.ready", int'(bus.req_ready), 1);
      check_eq("rst.enable", int'(bus.enable), 0);
      check_eq("rst.sell", int'(bus.sell), 0);
      check_eq("rst.resp_valid", int'(bus.resp_valid), 0);
      check_eq("rst.resp_code", int'(bus.resp_code), 0);

      // tag, op, slot, type, add_cyc, add_amt, code, lat, en, sell, tc, coins
      run_req("place_s2_t3", 0, 2, 3, 0, 0, 0, 4, 8'h04, 0, 3, 100);
      run_req("no_funds", 0, 3, 2, 0, 0, 1, 2, 0, 0, 0, 100);
      used_m[5]      = 1'b1;
      type_m[17:15]  = 3'd1;
      run_req("place_used", 0, 5, 1, 0, 0, 2, 2, 0, 0, 0, 100);
      run_req("sell_unused", 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 100);
      run_req("place_t0", 0, 4, 0, 0, 0, 3, 2, 0, 0, 0, 100);
      run_req("place_t5", 0, 4, 5, 0, 0, 3, 2, 0, 0, 0, 100);
      used_m[1]      = 1'b1;
      type_m[5:3]    = 3'd4;
      run_req("sell_s1_t4", 1, 1, 0, 0, 0, 0, 4, 0, 8'h02, 0, 300);
      run_req("op3", 3, 4, 1, 0, 0, 3, 2, 0, 0, 0, 300);
      used_m[6]      = 1'b1;
      type_m[20:18]  = 3'd2;
`ifdef TOWER_UPGRADE_EN
      run_req("upgrade", 2, 6, 0, 0, 0, 0, 4, 8'h40, 0, 3, 200);
`else
      run_req("op2_off", 2, 6, 0, 0, 0, 3, 2, 0, 0, 0, 300);
`endif

      do_reset();
      check_eq("rst2.coins", int'(bus.coins), 400);
      // credit 50 in the ISSUE cycle: 400 + 50 - 300
      run_req("issue_credit", 0, 3, 3, 2, 50, 0, 4, 8'h08, 0, 3, 150);
      // credit 100 in the CHECK cycle does not rescue: 150 < 200, then 250
      run_req("check_credit", 0, 4, 2, 1, 100, 1, 2, 0, 0, 0, 250);
      credit(3750);
      check_eq("credit.4000", int'(bus.coins), 4000);
      credit(200);
      check_eq("credit.sat", int'(bus.coins), 4095);

      // reset while in ISSUE aborts the request
      do_reset();
      check_eq("rst3.coins", int'(bus.coins), 400);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'd0;
      bus.req_slot  = 3'd4;
      bus.req_type  = 3'd1;
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check_eq("abort.issue_en", int'(bus.enable), 8'h10);
      Reset_n = 1'b0;
      @(negedge Clk);
      check_eq("abort.enable", int'(bus.enable), 0);
      Reset_n   = 1'b1;
      seen_resp = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (bus.resp_valid || bus.enable != '0) seen_resp = 1;
      end
      check_eq("abort.no_resp", seen_resp, 0);
      check_eq("abort.coins", int'(bus.coins), 400);
      check_eq("abort.ready", int'(bus.req_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tower_commander.md
Name: tower_commander

Overview:
Command initiator for the array of tower slots. It accepts place/sell requests from the player-input logic and checks them against slot status and the coin balance. Each accepted request is issued to exactly one slot as a single-cycle one-hot enable or sell pulse with type_com, followed by a status response. The block also owns the coin counter and credits kill rewards from the enemy logic.

Parameters:
NUM_SLOTS, 8, number of tower slots driven (slot index width = $clog2(NUM_SLOTS))
COIN_W, 12, coin counter width
START_COINS, 400, coin balance after reset
COST_UNIT, 100, cost of type t = t*COST_UNIT
MAX_TYPE, 4, highest legal tower type (legal types: 1..MAX_TYPE)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_op  in  2  0=place, 1=sell, 2=upgrade (feature), 3=reserved
req_slot  in  $clog2(NUM_SLOTS)  target slot
req_type  in  3  tower type for place
slot_used  in  NUM_SLOTS  per-slot is_used from the tower slots
slot_type  in  3*NUM_SLOTS  per-slot occur_type, slot i at [3i+2:3i]
enable  out  NUM_SLOTS  one-hot place pulse
sell  out  NUM_SLOTS  one-hot sell pulse
type_com  out  3  type presented with enable
coin_add_valid  in  1  reward credit strobe
coin_add  in  COIN_W  reward amount
coins  out  COIN_W  current balance
resp_valid  out  1  single-cycle response strobe
resp_code  out  2  0=OK, 1=NO_FUNDS, 2=SLOT_CONFLICT, 3=BAD_REQ

Behaviour:
- One clock, Clk. Reset is synchronous and active-low on Reset_n. All state updates happen on posedge Clk.
- Reset (Reset_n=0 at posedge) values:
  - FSM state: IDLE
  - coins = START_COINS
  - enable = 0, sell = 0, type_com = 0
  - resp_valid = 0, resp_code = 0
- Reset mid-operation aborts the request. No pulse and no response are emitted afterwards.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready; op, slot and type are latched at acceptance.
- State IDLE: on acceptance, go to CHECK.
- State CHECK (1 cycle): evaluate the latched request against slot_used/slot_type sampled this cycle.
  - Place:
    - type 0, type > MAX_TYPE, or slot >= NUM_SLOTS -> BAD_REQ
    - slot used -> SLOT_CONFLICT
    - coins < type*COST_UNIT -> NO_FUNDS
    - otherwise go to ISSUE
  - Sell: slot unused -> SLOT_CONFLICT; otherwise go to ISSUE.
  - op 3 -> BAD_REQ.
  - On any reject, go to RESP.
- State ISSUE (1 cycle):
  - Drive enable[slot]=1 with type_com=type, or sell[slot]=1. All other bits are 0.
  - Coin update:
    - place: coins -= cost
    - sell: coins += (slot_type*COST_UNIT)>>1, saturating at 2^COIN_W-1
  - Next state: WAIT.
- State WAIT (1 cycle): slot status settles. If slot_used does not reflect the command, resp_code = SLOT_CONFLICT. The coin change is not reverted. Next state: RESP.
- State RESP (1 cycle): resp_valid=1 with resp_code, then back to IDLE.
- Latency: acceptance to resp_valid is
  - 2 cycles for a reject (CHECK, RESP)
  - 4 cycles for an OK (CHECK, ISSUE, WAIT, RESP)
- Outside ISSUE, enable/sell/type_com are 0.
- coin_add_valid is honoured in every state except reset.
- Same-cycle credit and ISSUE deduction: coins = coins + coin_add - cost, computed in COIN_W+1 bits, then saturated to 2^COIN_W-1.
  - Underflow cannot occur, because CHECK guaranteed coins >= cost and credits only add.
- The CHECK decision uses the balance in that cycle. A same-cycle credit does not rescue NO_FUNDS.

Optional Feature:
Macro: TOWER_UPGRADE_EN
- Defined: op 2 = upgrade.
  - CHECK:
    - slot unused -> SLOT_CONFLICT
    - slot_type == MAX_TYPE -> BAD_REQ
    - coins < COST_UNIT -> NO_FUNDS
    - otherwise go to ISSUE
  - ISSUE: enable[slot]=1 with type_com = slot_type+1, coins -= COST_UNIT.
  - WAIT: additionally confirms that slot_type changed.
- Not defined: op 2 behaves like op 3 (BAD_REQ, no pulse, coins unchanged).

Test Plan:
- Reset then place slot 2, type 3, with coins 400 -> enable=8'b0000_0100 for one cycle with type_com=3; coins=100; resp_code OK 4 cycles after acceptance.
- With coins 100, place type 2 on a free slot -> resp_code NO_FUNDS after 2 cycles; no enable pulse; coins stay 100.
- Place on slot 5 with slot_used[5]=1 -> SLOT_CONFLICT; sell on unused slot 0 -> SLOT_CONFLICT; place type 0 or type 5 -> BAD_REQ.
- Sell slot 1 holding type 4 (slot_type=4), coins 100 -> sell=8'b0000_0010 pulse; coins=300; resp OK.
- coin_add_valid with coin_add=50 in the same cycle as an ISSUE deducting 300 from 400 -> coins=150. Separately, coins 4000 plus coin_add 200 -> coins saturate at 4095.
- Reset_n=0 in ISSUE -> next cycle enable=0, resp_valid never asserted, coins=400, req_ready=1.
- With TOWER_UPGRADE_EN: upgrade slot holding type 2 -> enable with type_com=3, coins -= 100.
- Without TOWER_UPGRADE_EN: op 2 -> BAD_REQ.
